qr_grid_writer: RTL and testbench

//  Inverse of the QR downsampler. Takes a latched 441-bit QR bit grid and renders it into the pixel frame buffer.

---
 rtl/qr_grid_writer_pkg.sv | 27 ++
 rtl/qr_grid_writer_scan_counter.sv | 58 +++++
 rtl/qr_grid_writer.sv | 166 ++++++++++++++++
 tb/tb_qr_grid_writer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/qr_grid_writer_pkg.sv
`default_nettype none
//============================================================================
// Module      : qr_pkg
// Description : Shared constants and FSM state type for the QR grid writer.
//               Optional feature macro QR_QUIET_ZONE_EN is consumed by the top.
// Revision    : 1.0 - initial release
//============================================================================
package qr_pkg;

    localparam int CODE_SIZE = 21;                      // modules per side (version 1)
    localparam int QR_BITS   = CODE_SIZE * CODE_SIZE;   // 441 grid bits
    localparam int ADDR_W    = 20;                      // frame-buffer address width
    localparam int QZ        = 4;                       // quiet-zone width in modules

    localparam int MS_W      = 9;                       // module_size / origin width
    localparam int MOD_W     = 5;                       // module index width (grid <= 31)
    localparam int POS_W     = 16;                      // pixel offset within rendered area
    localparam int ABS_W     = 17;                      // absolute pixel coordinate width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        DONE   = 2'd2
    } qr_wr_state_t;

endpackage
`default_nettype wire

// File: rtl/qr_grid_writer_scan_counter.sv
`default_nettype none
//============================================================================
// Module      : qr_scan_counter
// Description : Nested pixel-in-module / module-index counter for one axis,
//               with a running pixel offset and a carry-out on wrap.
// Revision    : 1.0 - initial release
//============================================================================
module qr_scan_counter
    import qr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [MS_W-1:0]  i_module_size,
    input  logic [MOD_W-1:0] i_grid_last,
    output logic [MOD_W-1:0] o_module_idx,
    output logic [POS_W-1:0] o_pos,
    output logic             o_carry
);

    logic [MS_W-1:0]  r_pix;
    logic [MOD_W-1:0] r_mod;
    logic [POS_W-1:0] r_pos;
    logic             w_pix_last;
    logic             w_mod_last;

    assign w_pix_last   = (r_pix == (i_module_size - MS_W'(1)));
    assign w_mod_last   = (r_mod == i_grid_last);
    assign o_carry      = i_advance & w_pix_last & w_mod_last;
    assign o_module_idx = r_mod;
    assign o_pos        = r_pos;

    // Step the pixel counter; carry into the module index; wrap everything after the last module.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_pix <= '0;
            r_mod <= '0;
            r_pos <= '0;
        end else if (i_advance) begin
            if (w_pix_last) begin
                r_pix <= '0;
                if (w_mod_last) begin
                    r_mod <= '0;
                    r_pos <= '0;
                end else begin
                    r_mod <= r_mod + MOD_W'(1);
                    r_pos <= r_pos + POS_W'(1);
                end
            end else begin
                r_pix <= r_pix + MS_W'(1);
                r_pos <= r_pos + POS_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qr_grid_writer.sv
`default_nettype none
//============================================================================
// Module      : qr_grid_writer
// Description : Renders a latched 21x21 QR bit grid into the frame buffer,
//               one pixel write per clock in raster order, each module drawn
//               as a module_size x module_size block.
//               Macro QR_QUIET_ZONE_EN adds a light QZ-module border.
// Revision    : 1.0 - initial release
//============================================================================
module qr_grid_writer
    import qr_pkg::*;
#(
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 320
)(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_render,
    input  logic [QR_BITS-1:0] qr_code,
    input  logic [MS_W-1:0]    module_size,
    input  logic [MS_W-1:0]    origin_x,
    input  logic [MS_W-1:0]    origin_y,
    output logic [ADDR_W-1:0]  write_address,
    output logic               write_data,
    output logic               write_enable,
    output logic               busy,
    output logic               done
);

`ifdef QR_QUIET_ZONE_EN
    localparam int c_GRID = CODE_SIZE + 2 * QZ;
`else
    localparam int c_GRID = CODE_SIZE;
`endif
    localparam logic [MOD_W-1:0] c_GRID_LAST = MOD_W'(c_GRID - 1);

    qr_wr_state_t       r_state;
    logic [QR_BITS-1:0] r_code;
    logic [MS_W-1:0]    r_ms;
    logic [MS_W-1:0]    r_ox;
    logic [MS_W-1:0]    r_oy;

    logic               w_accept;
    logic               w_beat;
    logic [MOD_W-1:0]   w_x_mod;
    logic [MOD_W-1:0]   w_y_mod;
    logic [POS_W-1:0]   w_x_pos;
    logic [POS_W-1:0]   w_y_pos;
    logic               w_x_carry;
    logic               w_y_carry;
    logic [MOD_W-1:0]   w_col;
    logic [MOD_W-1:0]   w_row;
    logic               w_in_code;
    logic [8:0]         w_idx;
    logic               w_data;
    logic [ABS_W-1:0]   w_abs_x;
    logic [ABS_W-1:0]   w_abs_y;
    logic               w_clip;
    logic [ADDR_W-1:0]  w_addr;

    assign w_accept = (r_state == IDLE) && start_render;
    assign w_beat   = (r_state == RENDER) && (r_ms != '0);

    qr_scan_counter u_x_cnt (
        .clk           (clk_in),
        .rst           (rst_in),
        .i_clear       (w_accept),
        .i_advance     (w_beat),
        .i_module_size (r_ms),
        .i_grid_last   (c_GRID_LAST),
        .o_module_idx  (w_x_mod),
        .o_pos         (w_x_pos),
        .o_carry       (w_x_carry)
    );

    // Row counter steps only when a full row of pixels wraps; its carry marks the last beat.
    qr_scan_counter u_y_cnt (
        .clk           (clk_in),
        .rst           (rst_in),
        .i_clear       (w_accept),
        .i_advance     (w_x_carry),
        .i_module_size (r_ms),
        .i_grid_last   (c_GRID_LAST),
        .o_module_idx  (w_y_mod),
        .o_pos         (w_y_pos),
        .o_carry       (w_y_carry)
    );

`ifdef QR_QUIET_ZONE_EN
    localparam logic [MOD_W-1:0] c_QZ_M  = MOD_W'(QZ);
    localparam logic [MOD_W-1:0] c_END_M = MOD_W'(QZ + CODE_SIZE);
    assign w_in_code = (w_x_mod >= c_QZ_M) && (w_x_mod < c_END_M) &&
                       (w_y_mod >= c_QZ_M) && (w_y_mod < c_END_M);
    assign w_col     = w_x_mod - c_QZ_M;
    assign w_row     = w_y_mod - c_QZ_M;
`else
    assign w_in_code = 1'b1;
    assign w_col     = w_x_mod;
    assign w_row     = w_y_mod;
`endif

    // Border modules fall outside the code and are drawn light; the index is only meaningful inside.
    assign w_idx   = 9'(w_row) * 9'(CODE_SIZE) + 9'(w_col);
    assign w_data  = w_in_code & r_code[w_idx];

    assign w_abs_x = ABS_W'(r_ox) + ABS_W'(w_x_pos);
    assign w_abs_y = ABS_W'(r_oy) + ABS_W'(w_y_pos);
    assign w_clip  = (w_abs_x >= ABS_W'(WIDTH)) || (w_abs_y >= ABS_W'(HEIGHT));
    assign w_addr  = ADDR_W'(w_abs_y) * ADDR_W'(WIDTH) + ADDR_W'(w_abs_x);

    // Control FSM with registered frame-buffer outputs; clipped beats still take their cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= IDLE;
            r_code        <= '0;
            r_ms          <= '0;
            r_ox          <= '0;
            r_oy          <= '0;
            write_address <= '0;
            write_data    <= 1'b0;
            write_enable  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    write_enable <= 1'b0;
                    if (start_render) begin
                        r_code  <= qr_code;
                        r_ms    <= module_size;
                        r_ox    <= origin_x;
                        r_oy    <= origin_y;
                        busy    <= 1'b1;
                        r_state <= RENDER;
                    end
                end
                RENDER: begin
                    if (r_ms == '0) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        write_address <= w_addr;
                        write_data    <= w_data;
                        write_enable  <= ~w_clip;
                        if (w_y_carry) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    write_enable <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qr_grid_writer.sv
`default_nettype none
//============================================================================
// Module      : tb_qr_grid_writer
// Description : Self-checking bench for qr_grid_writer against a reference
//               model derived from the rendering rules (QR_QUIET_ZONE_EN aware).
// Revision    : 1.0 - initial release
//============================================================================
module tb_qr_grid_writer;

    localparam int WIDTH  = 480;
    localparam int HEIGHT = 320;
`ifdef QR_QUIET_ZONE_EN
    localparam int G   = 29;
    localparam int OFF = 4;
`else
    localparam int G   = 21;
    localparam int OFF = 0;
`endif

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         start_render;
    logic [440:0] qr_code;
    logic [8:0]   module_size;
    logic [8:0]   origin_x;
    logic [8:0]   origin_y;
    logic [19:0]  write_address;
    logic         write_data;
    logic         write_enable;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    qr_grid_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_render  (start_render),
        .qr_code       (qr_code),
        .module_size   (module_size),
        .origin_x      (origin_x),
        .origin_y      (origin_y),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [440:0] rand_code();
        logic [440:0] c;
        for (int i = 0; i < 441; i++) c[i] = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Drive one render request and follow it cycle by cycle; abort_at >= 0 pulses reset at that beat.
    task automatic render(input logic [440:0] code, input int ms, input int ox, input int oy,
                          input int abort_at);
        int side, n, px, py, ax, ay, col, row;
        logic exp_d;
        logic clipped;
        side = G * ms;
        n    = side * side;
        @(negedge clk_in);
        qr_code      = code;
        module_size  = 9'(ms);
        origin_x     = 9'(ox);
        origin_y     = 9'(oy);
        start_render = 1'b1;
        @(posedge clk_in); #1;
        // inputs change after the latch and a second request arrives while busy
        qr_code      = ~code;
        module_size  = 9'($urandom);
        origin_x     = 9'($urandom);
        origin_y     = 9'($urandom);
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_we", 32'(write_enable), 32'd0);
        chk("first_done", 32'(done), 32'd0);
        for (int t = 0; t < n; t++) begin
            @(posedge clk_in); #1;
            start_render = 1'b0;
            px  = t % side;
            py  = t / side;
            ax  = ox + px;
            ay  = oy + py;
            col = px / ms - OFF;
            row = py / ms - OFF;
            exp_d   = (col >= 0 && col < 21 && row >= 0 && row < 21) ? code[col + row * 21] : 1'b0;
            clipped = (ax >= WIDTH) || (ay >= HEIGHT);
            chk("beat_busy", 32'(busy), 32'd1);
            chk("beat_we", 32'(write_enable), 32'(!clipped));
            if (!clipped) begin
                chk("beat_addr", 32'(write_address), 32'(ay * WIDTH + ax));
                chk("beat_data", 32'(write_data), 32'(exp_d));
            end
            if (t == abort_at) begin
                @(negedge clk_in);
                rst_in = 1'b1;
                @(posedge clk_in); #1;
                chk("abort_addr", 32'(write_address), 32'd0);
                chk("abort_data", 32'(write_data), 32'd0);
                chk("abort_we", 32'(write_enable), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                @(negedge clk_in);
                rst_in = 1'b0;
                repeat (3) begin
                    @(posedge clk_in); #1;
                    chk("post_abort_we", 32'(write_enable), 32'd0);
                    chk("post_abort_busy", 32'(busy), 32'd0);
                end
                return;
            end
        end
        @(posedge clk_in); #1;
        start_render = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_we", 32'(write_enable), 32'd0);
        @(posedge clk_in); #1;
        chk("after_done", 32'(done), 32'd0);
        chk("not_requeued", 32'(busy), 32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [440:0] c;
        rst_in       = 1'b1;
        start_render = 1'b0;
        qr_code      = '0;
        module_size  = '0;
        origin_x     = '0;
        origin_y     = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_addr", 32'(write_address), 32'd0);
        chk("rst_data", 32'(write_data), 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // all-dark code, ms=2 at the frame origin
        render({441{1'b1}}, 2, 0, 0, -1);

        // single dark module [0] at ms=3, origin (10,20)
        c = '0;
        c[0] = 1'b1;
        render(c, 3, 10, 20, -1);

        // right-edge clip
        render(rand_code(), 2, 470, 0, -1);

        // zero module size
        render(rand_code(), 0, 3, 3, -1);

        // reset during beat 100, then a normal render
        render({441{1'b1}}, 2, 5, 7, 100);
        render(rand_code(), 1, 0, 0, -1);

        // randomized renders including bottom/right clipping
        for (int i = 0; i < 3; i++) begin
            render(rand_code(), int'($urandom_range(1, 3)), int'($urandom_range(0, 511)),
                   int'($urandom_range(0, 400)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
